// File: rtl/ice40_banked_ram_pkg.sv
// Shared constants and types for the banked iCE40 BRAM memory.
package ice40_banked_ram_pkg;

    // Geometry of a single SB_RAM40_4K configured as 512x8.
    localparam int BANK_ADDR_BITS = 9;
    localparam int BANK_BYTES     = 512;

    // Controller states: clearing all memory, then serving the ports.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Width of the bank-select field; at least one bit so a single-bank build still has a legal vector.
    function automatic int bankSelBits(input int numBanks);
        return (numBanks > 1) ? $clog2(numBanks) : 1;
    endfunction

endpackage

// File: rtl/ice40_banked_ram_if.sv
// CPU and host/debug port bundle for the banked memory.
interface ice40_banked_ram_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] in_address;
    logic [7:0]            in_write;
    logic                  in_write_enable;
    logic [7:0]            out_read;
    logic                  out_ready;
    logic                  in_host_request;
    logic                  out_host_grant;
    logic [ADDR_WIDTH-1:0] in_host_address;
    logic [7:0]            in_host_write;
    logic                  in_host_write_enable;

    // Requester side: the CPU core plus the host/debug agent.
    modport master (
        output in_address, in_write, in_write_enable,
        output in_host_request, in_host_address, in_host_write, in_host_write_enable,
        input  out_read, out_ready, out_host_grant
    );

    // Memory side.
    modport slave (
        input  in_address, in_write, in_write_enable,
        input  in_host_request, in_host_address, in_host_write, in_host_write_enable,
        output out_read, out_ready, out_host_grant
    );

endinterface

// File: rtl/ice40_banked_ram_bank.sv
// One 512x8 block RAM, written so synthesis maps it onto a single SB_RAM40_4K.
module ice40_ram_bank
    import ice40_banked_ram_pkg::*;
(
    input  logic                      clock,
    input  logic [BANK_ADDR_BITS-1:0] addr_i,
    input  logic [7:0]                wdata_i,
    input  logic                      we_i,
    output logic [7:0]                rdata_o
);

    logic [7:0] mem_q [BANK_BYTES];
    logic [7:0] rdata_q;

    // Synchronous write and registered read on the same clock, matching the BRAM port timing.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ice40_banked_ram.sv
// Multi-bank iCE40 BRAM memory: clears itself after reset, then serves the CPU
// port, handing exclusive access to the host/debug port on request.
module ice40_banked_ram
    import ice40_banked_ram_pkg::*;
#(
    parameter int         NUM_BANKS  = 8,
    parameter int         ADDR_WIDTH = 16,
    parameter logic [7:0] FILL_VALUE = 8'h00
) (
    input  logic                clock,
    input  logic                reset,
    ice40_banked_ram_if.slave   bus
);

    localparam int LOG2_BANKS = $clog2(NUM_BANKS);
    localparam int EFF_W      = BANK_ADDR_BITS + LOG2_BANKS;
    localparam int SEL_W      = bankSelBits(NUM_BANKS);
    localparam int BANK_SLOTS = 1 << SEL_W;
    localparam logic [EFF_W-1:0] LAST_ADDR = EFF_W'(NUM_BANKS * BANK_BYTES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [EFF_W-1:0] clearAddr_q;
    logic [EFF_W-1:0] clearAddr_d;
    logic             grant_q;
    logic             grant_d;
    logic             ready_q;
    logic             ready_d;
    logic             readValid_q;
    logic             readValid_d;
    logic [SEL_W-1:0] readBank_q;

    logic             clearDone;
    logic [EFF_W-1:0] memAddr;
    logic [7:0]       memWdata;
    logic             memWe;
    logic [SEL_W-1:0] memBank;
    logic [7:0]       bankRdata [BANK_SLOTS];

    // The last clear write happens in the cycle the counter sits on the top address.
    assign clearDone = (state_q == ST_CLEAR) && (clearAddr_q == LAST_ADDR);

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave CLEAR once every location has been written, then stay in RUN.
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_CLEAR) && clearDone) begin
            state_d = ST_RUN;
        end
    end

    // Owner mux and next values of the registered port outputs.
    always_comb begin
        memAddr     = clearAddr_q;
        memWdata    = FILL_VALUE;
        memWe       = 1'b1;
        clearAddr_d = clearAddr_q;
        grant_d     = 1'b0;
        ready_d     = 1'b0;
        readValid_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clearAddr_d = clearAddr_q + EFF_W'(1);
                if (clearDone) begin
                    grant_d = bus.in_host_request;
                    ready_d = !bus.in_host_request;
                end
            end
            ST_RUN: begin
                readValid_d = 1'b1;
                grant_d     = bus.in_host_request;
                ready_d     = !bus.in_host_request;
                if (grant_q) begin
                    memAddr  = bus.in_host_address[EFF_W-1:0];
                    memWdata = bus.in_host_write;
                    memWe    = bus.in_host_write_enable;
                end else begin
                    memAddr  = bus.in_address[EFF_W-1:0];
                    memWdata = bus.in_write;
                    memWe    = bus.in_write_enable & ready_q;
                end
            end
            default: begin
                memWe = 1'b0;
            end
        endcase
        if (reset) begin
            memWe = 1'b0;
        end
    end

    // Clear counter, arbiter outputs and the bank select that travels with each BRAM read.
    always_ff @(posedge clock) begin
        if (reset) begin
            clearAddr_q <= '0;
            grant_q     <= 1'b0;
            ready_q     <= 1'b0;
            readValid_q <= 1'b0;
            readBank_q  <= '0;
        end else begin
            clearAddr_q <= clearAddr_d;
            grant_q     <= grant_d;
            ready_q     <= ready_d;
            readValid_q <= readValid_d;
            readBank_q  <= memBank;
        end
    end

    // Bank select is the address field above the row; a single bank has nothing to decode.
    generate
        if (LOG2_BANKS == 0) begin : g_oneBank
            assign memBank = '0;
        end else begin : g_multiBank
            assign memBank = memAddr[EFF_W-1:BANK_ADDR_BITS];
        end
    endgenerate

    // Address bits above the linear space are ignored, so the memory mirrors.
    generate
        if (ADDR_WIDTH > EFF_W) begin : g_mirror
            logic unusedAddrBits;
            assign unusedAddrBits = ^{bus.in_address[ADDR_WIDTH-1:EFF_W],
                                      bus.in_host_address[ADDR_WIDTH-1:EFF_W]};
        end
    endgenerate

    // Every bank sees the owner's row and data; only the selected bank gets the write strobe.
    genvar i;
    generate
        for (i = 0; i < BANK_SLOTS; i++) begin : g_bank
            if (i < NUM_BANKS) begin : g_used
                ice40_ram_bank u_bank (
                    .clock   (clock),
                    .addr_i  (memAddr[BANK_ADDR_BITS-1:0]),
                    .wdata_i (memWdata),
                    .we_i    (memWe && (memBank == SEL_W'(i))),
                    .rdata_o (bankRdata[i])
                );
            end else begin : g_pad
                assign bankRdata[i] = 8'h00;
            end
        end
    endgenerate

    assign bus.out_read       = readValid_q ? bankRdata[readBank_q] : 8'h00;
    assign bus.out_ready      = ready_q;
    assign bus.out_host_grant = grant_q;

endmodule

// File: tb/tb_ice40_banked_ram.sv
// Directed bench for ice40_banked_ram: an 8-bank and a 1-bank instance share one clock.
module tb_ice40_banked_ram;

    localparam logic [7:0] FILL8 = 8'hE7;
    localparam logic [7:0] FILL1 = 8'h3B;

    logic clock = 1'b0;
    logic reset8;
    logic reset1;
    int   vectors = 0;
    int   miscompares = 0;
    int   n;

    ice40_banked_ram_if #(.ADDR_WIDTH(16)) bus8 ();
    ice40_banked_ram_if #(.ADDR_WIDTH(16)) bus1 ();

    ice40_banked_ram #(.NUM_BANKS(8), .ADDR_WIDTH(16), .FILL_VALUE(FILL8)) dut8 (
        .clock (clock),
        .reset (reset8),
        .bus   (bus8.slave)
    );

    ice40_banked_ram #(.NUM_BANKS(1), .ADDR_WIDTH(16), .FILL_VALUE(FILL1)) dut1 (
        .clock (clock),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive the 8-bank CPU port for one cycle.
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic we);
        bus8.in_address      = addr;
        bus8.in_write        = data;
        bus8.in_write_enable = we;
        tick();
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Hard stop in case something wedges the sequence below.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset8 = 1'b1;
        reset1 = 1'b1;
        bus8.in_address = '0;  bus8.in_write = '0;  bus8.in_write_enable = 1'b0;
        bus8.in_host_request = 1'b0; bus8.in_host_address = '0;
        bus8.in_host_write = '0; bus8.in_host_write_enable = 1'b0;
        bus1.in_address = '0;  bus1.in_write = '0;  bus1.in_write_enable = 1'b0;
        bus1.in_host_request = 1'b0; bus1.in_host_address = '0;
        bus1.in_host_write = '0; bus1.in_host_write_enable = 1'b0;

        // Reset state and clear length of the 8-bank build.
        tick();
        checkOutput("rst_ready", 32'(bus8.out_ready), 32'd0);
        checkOutput("rst_grant", 32'(bus8.out_host_grant), 32'd0);
        checkOutput("rst_read", 32'(bus8.out_read), 32'h00);
        reset8 = 1'b0;
        n = 0;
        while (bus8.out_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        checkOutput("clear_len8", 32'(n), 32'd4096);
        checkOutput("first_run_read", 32'(bus8.out_read), 32'h00);
        checkOutput("first_run_grant", 32'(bus8.out_host_grant), 32'd0);
        applyStimulus(16'h0000, 8'h00, 1'b0);
        checkOutput("fill_0000", 32'(bus8.out_read), 32'(FILL8));
        applyStimulus(16'h0FFF, 8'h00, 1'b0);
        checkOutput("fill_0FFF", 32'(bus8.out_read), 32'(FILL8));

        // Writes into banks 1 and 2, read back with one-cycle latency.
        applyStimulus(16'h0200, 8'hA5, 1'b1);
        applyStimulus(16'h0400, 8'h5A, 1'b1);
        applyStimulus(16'h0200, 8'h00, 1'b0);
        checkOutput("rd_0200", 32'(bus8.out_read), 32'hA5);
        applyStimulus(16'h0400, 8'h00, 1'b0);
        checkOutput("rd_0400", 32'(bus8.out_read), 32'h5A);

        // Mirroring above DEPTH=4096.
        applyStimulus(16'h1234, 8'h3C, 1'b1);
        applyStimulus(16'h0234, 8'h00, 1'b0);
        checkOutput("mirror_0234", 32'(bus8.out_read), 32'h3C);

        // Host strobe is ignored while not granted.
        bus8.in_host_address = 16'h0300;
        bus8.in_host_write = 8'h99;
        bus8.in_host_write_enable = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        bus8.in_host_write_enable = 1'b0;
        applyStimulus(16'h0300, 8'h00, 1'b0);
        checkOutput("host_ignored", 32'(bus8.out_read), 32'(FILL8));

        // Host takes over: grant next cycle, CPU stalled and its write dropped.
        bus8.in_host_request = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        checkOutput("req_grant", 32'(bus8.out_host_grant), 32'd1);
        checkOutput("req_ready", 32'(bus8.out_ready), 32'd0);
        bus8.in_host_address = 16'h0010;
        bus8.in_host_write = 8'h77;
        bus8.in_host_write_enable = 1'b1;
        applyStimulus(16'h0200, 8'hFF, 1'b1);
        bus8.in_host_write_enable = 1'b0;
        applyStimulus(16'h0200, 8'hFF, 1'b1);
        checkOutput("host_rd_0010", 32'(bus8.out_read), 32'h77);
        bus8.in_host_address = 16'h0200;
        applyStimulus(16'h0200, 8'hFF, 1'b1);
        checkOutput("cpu_write_dropped", 32'(bus8.out_read), 32'hA5);

        // Release: CPU ready next cycle; the host's last read still shows up on out_read.
        bus8.in_host_request = 1'b0;
        applyStimulus(16'h0010, 8'h00, 1'b0);
        checkOutput("rel_ready", 32'(bus8.out_ready), 32'd1);
        checkOutput("rel_grant", 32'(bus8.out_host_grant), 32'd0);
        checkOutput("owner_tail", 32'(bus8.out_read), 32'hA5);
        applyStimulus(16'h0010, 8'h00, 1'b0);
        checkOutput("cpu_rd_0010", 32'(bus8.out_read), 32'h77);

        // Reset mid-RUN drops the grant; reset mid-CLEAR restarts the full sweep.
        applyStimulus(16'h0020, 8'h11, 1'b1);
        applyStimulus(16'h0020, 8'h00, 1'b0);
        checkOutput("rd_0020", 32'(bus8.out_read), 32'h11);
        bus8.in_host_request = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        reset8 = 1'b1;
        tick();
        checkOutput("reset_grant", 32'(bus8.out_host_grant), 32'd0);
        checkOutput("reset_ready", 32'(bus8.out_ready), 32'd0);
        reset8 = 1'b0;
        bus8.in_host_request = 1'b0;
        repeat (100) tick();
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0;
        n = 0;
        while (bus8.out_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        checkOutput("reclear_len8", 32'(n), 32'd4096);
        applyStimulus(16'h0020, 8'h00, 1'b0);
        checkOutput("reclear_0020", 32'(bus8.out_read), 32'(FILL8));
        applyStimulus(16'h0200, 8'h00, 1'b0);
        checkOutput("reclear_0200", 32'(bus8.out_read), 32'(FILL8));

        // Single-bank build: 512-cycle clear, pending host request wins on RUN entry.
        bus1.in_host_request = 1'b1;
        tick();
        reset1 = 1'b0;
        n = 0;
        while (bus1.out_host_grant !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checkOutput("clear_len1", 32'(n), 32'd512);
        checkOutput("host_wins_ready", 32'(bus1.out_ready), 32'd0);
        bus1.in_host_address = 16'h01FF;
        bus1.in_host_write = 8'hC4;
        bus1.in_host_write_enable = 1'b1;
        tick();
        bus1.in_host_write_enable = 1'b0;
        bus1.in_host_address = 16'hFFFF;
        tick();
        checkOutput("host_mirror1", 32'(bus1.out_read), 32'hC4);
        bus1.in_host_request = 1'b0;
        tick();
        checkOutput("rel_ready1", 32'(bus1.out_ready), 32'd1);
        bus1.in_address = 16'hFFFF;
        tick();
        checkOutput("cpu_mirror1", 32'(bus1.out_read), 32'hC4);
        bus1.in_address = 16'h0100;
        tick();
        checkOutput("fill1_0100", 32'(bus1.out_read), 32'(FILL1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
